// File: rtl/shift_seq_ctrl.sv
// Multi-step shift sequencer: splits a 0..15 shift into <=3-bit steps run through an external 4-bit barrel shifter.
// Optional SHIFT_SEQ_SHORTCUT_EN: amounts >= WIDTH complete immediately with a zero result.
`timescale 1ns/1ps
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic [WIDTH-1:0] sh_data,
  output logic [1:0]       sh_shift,
  output logic             sh_dire,
  input  logic [WIDTH-1:0] sh_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'(3);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [AMT_W-1:0] rem, rem_nxt;
  logic [AMT_W-1:0] step;
  logic             dir, dir_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      dir   <= dir_nxt;
    end
  end

  // Largest step the 2-bit shifter amount can express; the last step takes the remainder.
  always_comb begin
    step = (rem > MAX_STEP) ? MAX_STEP : rem;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    dir_nxt   = dir;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sh_shift  = 2'd0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt = in_data;
          rem_nxt = in_amt;
          dir_nxt = in_dir;
          if (in_amt == '0) begin
            state_nxt = DONE;
`ifdef SHIFT_SEQ_SHORTCUT_EN
          end else if (32'(in_amt) >= 32'(WIDTH)) begin
            acc_nxt   = '0;
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        sh_shift = step[1:0];
        acc_nxt  = sh_result;
        rem_nxt  = rem - step;
        if (rem == step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // acc only moves on accept or in RUN, so out_data holds while a result waits.
  assign sh_data  = acc;
  assign sh_dire  = dir;
  assign out_data = acc;
  assign busy     = (state != IDLE);

endmodule
